convert_fixed_to_float_seq: RTL and testbench

- Sequential converter from 32-bit two's-complement fixed point to IEEE-754 single precision.
- It is the return path of the float-to-fixed datapath: fixed-point results from the arithmetic core are repacked as floats.
- Operation is multi-cycle with a START/BUSY/DONE handshake.
- Normalization is an iterative 5-step binary-search left shift, so latency is fixed.

---
 rtl/convert_fixed_to_float_seq.sv | 111 +++++++++++
 tb/tb_convert_fixed_to_float_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/convert_fixed_to_float_seq.sv
// Multi-cycle converter from 32-bit two's-complement fixed point to IEEE-754 single.
// Normalization is a fixed 5-step binary-search left shift, giving a constant 6-cycle latency.
//
// state | meaning
// IDLE  | waiting for START; operand captured on the accepting edge
// NORM  | five shift steps of 16,8,4,2,1 that bring the leading one to bit 31
// PACK  | assemble sign/exponent/mantissa into FLOAT, pulse DONE
module convert_fixed_to_float_seq #(
  parameter int FRAC = 30
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] FIXED,
  output logic [31:0] FLOAT,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, PACK = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  k_q, k_d;
  logic        s_q, s_d;
  logic        z_q, z_d;
  logic [31:0] float_q, float_d;
  logic        done_q, done_d;

  logic [5:0]  sh;
  logic        top_zero;
  logic [9:0]  exp_w;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      m_q     <= 32'd0;
      k_q     <= 5'd0;
      s_q     <= 1'b0;
      z_q     <= 1'b0;
      float_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      m_q     <= m_d;
      k_q     <= k_d;
      s_q     <= s_d;
      z_q     <= z_d;
      float_q <= float_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = NORM;
      NORM:    if (step_q == 3'd4) state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift amount halves each step; the top S bits being zero means the leading one is lower.
  assign sh       = 6'd16 >> step_q;
  assign top_zero = ((m_q >> (6'd32 - sh)) == 32'd0);
  assign exp_w    = 10'd158 - {5'd0, k_q} - 10'(FRAC);

  always_comb begin
    step_d  = step_q;
    m_d     = m_q;
    k_d     = k_q;
    s_d     = s_q;
    z_d     = z_q;
    float_d = float_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          s_d    = FIXED[31];
          m_d    = FIXED[31] ? (32'd0 - FIXED) : FIXED;
          z_d    = (FIXED == 32'd0);
          k_d    = 5'd0;
          step_d = 3'd0;
        end
      end
      NORM: begin
        if (top_zero) begin
          m_d = m_q << sh;
          k_d = k_q + sh[4:0];
        end
        step_d = step_q + 3'd1;
      end
      PACK: begin
        float_d = z_q ? 32'd0 : {s_q, exp_w[7:0], m_q[30:8]};
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    BUSY  = (state_q != IDLE);
    DONE  = done_q;
    FLOAT = float_q;
  end

endmodule

// File: tb/tb_convert_fixed_to_float_seq.sv
// Bench for convert_fixed_to_float_seq: two instances (FRAC=30 and FRAC=0) share stimulus
// and are checked against an arithmetic leading-one reference model.
module tb_convert_fixed_to_float_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [31:0] FIXED = 32'd0;
  logic [31:0] float30, float0;
  logic        busy30, busy0, done30, done0;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  convert_fixed_to_float_seq #(.FRAC(30)) dut30 (
    .CLK(CLK), .RST(RST), .START(START), .FIXED(FIXED),
    .FLOAT(float30), .BUSY(busy30), .DONE(done30)
  );

  convert_fixed_to_float_seq #(.FRAC(0)) dut0 (
    .CLK(CLK), .RST(RST), .START(START), .FIXED(FIXED),
    .FLOAT(float0), .BUSY(busy0), .DONE(done0)
  );

  // Value = x / 2^frac; find the leading one of |x| and truncate to 23 fraction bits.
  function automatic logic [31:0] model(input logic [31:0] x, input int frac);
    logic           s;
    longint unsigned mag;
    longint unsigned mant;
    int             p;
    int             e;
    logic [7:0]     e8;
    s   = x[31];
    mag = 64'(x);
    if (s) mag = 64'd4294967296 - mag;
    if (mag == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 33; i++) if ((mag >> i) != 0) p = i;
    e    = 127 + p - frac;
    e8   = e[7:0];
    mant = ((mag << 23) >> p) & 64'h7FFFFF;
    return {s, e8, mant[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulse START with x, then look for DONE on both instances within a bounded window.
  task automatic convert(input logic [31:0] x, input string tag);
    logic [31:0] e30, e0;
    int lat30, lat0;
    e30 = model(x, 30);
    e0  = model(x, 0);
    START = 1'b1;
    FIXED = x;
    tick();
    START = 1'b0;
    FIXED = $urandom;
    check({tag, "_busy"}, 32'(busy30), 32'd1);
    lat30 = 0;
    lat0  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done30 && lat30 == 0) lat30 = c;
      if (done0 && lat0 == 0) lat0 = c;
      if (lat30 != 0 && lat0 != 0) break;
    end
    check({tag, "_lat30"}, 32'(lat30), 32'd6);
    check({tag, "_lat0"}, 32'(lat0), 32'd6);
    check({tag, "_f30"}, float30, e30);
    check({tag, "_f0"}, float0, e0);
    check({tag, "_busy_end"}, 32'(busy30), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] r;

    // Reset then idle
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_float", float30, 32'd0);
      check("idle_busy", 32'(busy30), 32'd0);
      check("idle_done", 32'(done30), 32'd0);
    end

    // Directed values with hand-derived results
    convert(32'h40000000, "one");
    check("one_const", float30, 32'h3F800000);
    convert(32'hC0000000, "mone");
    check("mone_const", float30, 32'hBF800000);
    convert(32'h20000000, "half");
    check("half_const", float30, 32'h3F000000);
    convert(32'h80000000, "mtwo");
    check("mtwo_const", float30, 32'hC0000000);
    convert(32'h00000001, "lsb");
    check("lsb_const", float30, 32'h30800000);
    convert(32'h7FFFFFFF, "max");
    check("max_const30", float30, 32'h3FFFFFFF);
    check("max_const0", float0, 32'h4EFFFFFF);
    convert(32'hFFFFFFFF, "m1");
    check("m1_const0", float0, 32'hBF800000);
    convert(32'h00000000, "zero");
    check("zero_const", float30, 32'h00000000);

    // DONE is a single-cycle pulse
    tick();
    check("done_pulse", 32'(done30), 32'd0);

    // Mid-flight STARTs ignored; START in the DONE cycle accepted
    START = 1'b1;
    FIXED = 32'h40000000;
    tick();
    START = 1'b0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2 || c == 4) begin
        START = 1'b1;
        FIXED = 32'hC0000000;
      end else begin
        START = 1'b0;
        FIXED = 32'h12345678;
      end
      tick();
      if (done30) begin
        lat = c;
        break;
      end
    end
    START = 1'b0;
    check("b2b_lat1", 32'(lat), 32'd6);
    check("b2b_f1", float30, 32'h3F800000);
    START = 1'b1;
    FIXED = 32'hC0000000;
    tick();
    START = 1'b0;
    FIXED = 32'd0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done30) begin
        lat = c;
        break;
      end
    end
    check("b2b_lat2", 32'(lat), 32'd6);
    check("b2b_f2", float30, 32'hBF800000);

    // Reset in the middle of a conversion
    START = 1'b1;
    FIXED = 32'h20000000;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_busy", 32'(busy30), 32'd0);
    check("abort_float", float30, 32'd0);
    check("abort_done", 32'(done30), 32'd0);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (done30 || busy30) lat = c;
    end
    check("abort_quiet", 32'(lat), 32'd0);
    convert(32'h40000000, "post_abort");

    // Randomized operands, including sparse ones to exercise every shift depth
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (i % 3 == 1) r = r >> $urandom_range(31, 0);
      if (i % 3 == 2) r = 32'd0 - (r >> $urandom_range(31, 0));
      convert(r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
